// File: rtl/id_stage_pipelined.sv
// Instruction-decode stage for the pipelined RISC-V datapath.
// Owns the register file (with write-back bypass), builds I/S/B/U/J immediates,
// decodes control and holds the ID/EX pipeline register. A valid/ready handshake
// handles stalls and flushes, and a load-use hazard inserts one bubble.
// Ports:
//   clk, reset (sync, active-low)
//   if_valid/if_pc/if_instr : instruction offered by fetch; id_ready accepts it
//   ex_ready, flush         : downstream backpressure and branch-redirect kill
//   wb_reg_write/wb_rd/wb_data : register file write port (bypassed to reads)
//   id_*                    : registered ID/EX payload and control
module id_stage_pipelined #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  output logic            id_ready,
  input  logic            ex_ready,
  input  logic            flush,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_rs1_data,
  output logic [XLEN-1:0] id_rs2_data,
  output logic [XLEN-1:0] id_imm,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [4:0]      id_rd,
  output logic [3:0]      id_func,
  output logic            id_alu_src,
  output logic            id_mem_to_reg,
  output logic            id_reg_write,
  output logic            id_mem_read,
  output logic            id_mem_write,
  output logic            id_branch,
  output logic            id_jump,
  output logic [1:0]      id_alu_op,
  output logic            id_illegal
);

  localparam int unsigned RAW    = $clog2(NREGS);
  localparam int unsigned CTRL_W = 10;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Control vector: {alu_src, mem_to_reg, reg_write, mem_read, mem_write,
  //                  branch, jump, alu_op[1:0], illegal}
  logic [CTRL_W-1:0] dec_ctrl;
  logic [CTRL_W-1:0] ctrl_q;
  logic [XLEN-1:0]   dec_imm;
  logic              uses_rs1;
  logic              uses_rs2;

  logic [XLEN-1:0] regs [NREGS];
  logic [RAW-1:0]  rs1_idx;
  logic [RAW-1:0]  rs2_idx;
  logic [RAW-1:0]  wb_idx;
  logic            wb_we;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  logic hz;
  logic adv;

  logic [6:0] opcode;
  assign opcode = if_instr[6:0];

  assign rs1_idx = if_instr[15 +: RAW];
  assign rs2_idx = if_instr[20 +: RAW];
  assign wb_idx  = wb_rd[RAW-1:0];
  assign wb_we   = wb_reg_write && (wb_idx != '0);

  // Opcode decode, immediate generation and source-register usage
  always_comb begin
    dec_ctrl = '0;
    dec_imm  = '0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_R: begin
        dec_ctrl = 10'b0010000_10_0;
        uses_rs2 = 1'b1;
      end
      OP_IALU: begin
        dec_ctrl = 10'b1010000_10_0;
        dec_imm  = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
      end
      OP_LOAD: begin
        dec_ctrl = 10'b1111000_00_0;
        dec_imm  = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
      end
      OP_STORE: begin
        dec_ctrl = 10'b1000100_00_0;
        dec_imm  = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        dec_ctrl = 10'b0000010_01_0;
        dec_imm  = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7],
                    if_instr[30:25], if_instr[11:8], 1'b0};
        uses_rs2 = 1'b1;
      end
      OP_LUI: begin
        dec_ctrl = 10'b1010000_11_0;
        dec_imm  = {{(XLEN-32){if_instr[31]}}, if_instr[31:12], 12'b0};
        uses_rs1 = 1'b0;
      end
      OP_JAL: begin
        dec_ctrl = 10'b0010001_11_0;
        dec_imm  = {{(XLEN-21){if_instr[31]}}, if_instr[31], if_instr[19:12],
                    if_instr[20], if_instr[30:21], 1'b0};
        uses_rs1 = 1'b0;
      end
      OP_JALR: begin
        dec_ctrl = 10'b1010001_11_0;
        dec_imm  = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
      end
      default: dec_ctrl = 10'b0000000_00_1;
    endcase
  end

  // Register reads: x0 is hard zero, a same-cycle write-back wins over the array
  always_comb begin
    rs1_val = regs[rs1_idx];
    rs2_val = regs[rs2_idx];
    if (rs1_idx == '0)                      rs1_val = '0;
    else if (wb_we && (wb_idx == rs1_idx))  rs1_val = wb_data;
    if (rs2_idx == '0)                      rs2_val = '0;
    else if (wb_we && (wb_idx == rs2_idx))  rs2_val = wb_data;
  end

  // Load-use: the registered load's destination feeds the incoming instruction
  assign hz = id_valid && id_mem_read && (id_rd != 5'd0) &&
              ((uses_rs1 && (if_instr[19:15] == id_rd)) ||
               (uses_rs2 && (if_instr[24:20] == id_rd)));

  assign adv      = ex_ready || !id_valid;
  assign id_ready = flush || (adv && !hz);

  // Register file write port
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_we) begin
      regs[wb_idx] <= wb_data;
    end
  end

  // ID/EX pipeline register; control is cleared whenever the slot goes empty
  always_ff @(posedge clk) begin
    if (!reset) begin
      id_valid    <= 1'b0;
      ctrl_q      <= '0;
      id_pc       <= '0;
      id_rs1_data <= '0;
      id_rs2_data <= '0;
      id_imm      <= '0;
      id_rs1      <= '0;
      id_rs2      <= '0;
      id_rd       <= '0;
      id_func     <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
      ctrl_q   <= '0;
    end else if (adv) begin
      if (hz || !if_valid) begin
        id_valid <= 1'b0;
        ctrl_q   <= '0;
      end else begin
        id_valid    <= 1'b1;
        ctrl_q      <= dec_ctrl;
        id_pc       <= if_pc;
        id_rs1_data <= rs1_val;
        id_rs2_data <= rs2_val;
        id_imm      <= dec_imm;
        id_rs1      <= if_instr[19:15];
        id_rs2      <= if_instr[24:20];
        id_rd       <= if_instr[11:7];
        id_func     <= {if_instr[30], if_instr[14:12]};
      end
    end
  end

  assign id_alu_src    = ctrl_q[9];
  assign id_mem_to_reg = ctrl_q[8];
  assign id_reg_write  = ctrl_q[7];
  assign id_mem_read   = ctrl_q[6];
  assign id_mem_write  = ctrl_q[5];
  assign id_branch     = ctrl_q[4];
  assign id_jump       = ctrl_q[3];
  assign id_alu_op     = ctrl_q[2:1];
  assign id_illegal    = ctrl_q[0];

endmodule
